// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: fetch FSM states,
// instruction field positions and PC update select encodings.
package fetch_unit_pkg;

  // Fetch FSM states
  typedef enum logic [1:0] {
    F_IDLE = 2'b00,
    F_WAIT = 2'b01,
    F_DONE = 2'b10
  } fetch_state_t;

  // Instruction field MSB positions inside the 16-bit IR
  localparam int OPC_MSB = 15;
  localparam int RD_MSB  = 11;
  localparam int RS_MSB  = 9;
  localparam int IMM_MSB = 7;

  // PC update select encodings
  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_JMP  = 2'b10;
  localparam logic [1:0] PC_CLR  = 2'b11;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register with update mux and jump-completed pulse.
module fetch_unit_pc_reg
  import fetch_unit_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_pc_pulse,
  input  logic [1:0]      pc_ctrl,
  input  logic [7:0]      imm,
  output logic [PC_W-1:0] pc,
  output logic            pc_jump
);

  logic [PC_W-1:0] pc_next;

  // Select the candidate next PC from the update control code
  always_comb begin
    pc_next = pc;
    case (pc_ctrl)
      PC_HOLD: pc_next = pc;
      PC_INC:  pc_next = pc + PC_W'(1);
      PC_JMP:  pc_next = PC_W'(imm);
      PC_CLR:  pc_next = '0;
      default: pc_next = pc;
    endcase
  end

  // Apply the PC update on the strobe; flag a completed jump for one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= '0;
      pc_jump <= 1'b0;
    end else begin
      pc_jump <= en_pc_pulse && (pc_ctrl == PC_JMP);
      if (en_pc_pulse) begin
        pc <= pc_next;
      end else begin
        pc <= pc;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues ROM reads, holds the
// instruction register and decodes its fields for the control FSM.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_fetch_pulse,
  input  logic            en_pc_pulse,
  input  logic [1:0]      pc_ctrl,
  output logic [PC_W-1:0] rom_addr,
  output logic            rom_req,
  input  logic [15:0]     rom_data,
  input  logic            rom_valid,
  output logic            en1,
  output logic            pc_jump,
  output logic [3:0]      opcode,
  output logic [1:0]      rd,
  output logic [1:0]      rs,
  output logic [7:0]      imm,
  output logic [PC_W-1:0] pc,
  output logic            fetch_err
);

  // Last counter value before the abort; the abort edge makes the count reach TIMEOUT
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  fetch_state_t state;
  fetch_state_t next_state;
  logic [15:0]  ir;
  logic [7:0]   tcnt;
  logic         to_hit;
  logic         ir_load;
  logic         abort;
  logic         addr_load;
  logic         busy_req;

  assign to_hit = (tcnt == TO_LAST);

  // Decode outputs are plain slices of the registered IR
  assign opcode = ir[OPC_MSB -: 4];
  assign rd     = ir[RD_MSB  -: 2];
  assign rs     = ir[RS_MSB  -: 2];
  assign imm    = ir[IMM_MSB -: 8];

  fetch_unit_pc_reg #(
    .PC_W(PC_W)
  ) u_pc_reg (
    .clk        (clk),
    .rst        (rst),
    .en_pc_pulse(en_pc_pulse),
    .pc_ctrl    (pc_ctrl),
    .imm        (imm),
    .pc         (pc),
    .pc_jump    (pc_jump)
  );

  // Fetch FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= F_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Fetch FSM next-state logic; valid data wins over a coincident timeout
  always_comb begin
    next_state = state;
    case (state)
      F_IDLE: begin
        if (en_fetch_pulse) next_state = F_WAIT;
        else                next_state = F_IDLE;
      end
      F_WAIT: begin
        if (rom_valid)   next_state = F_DONE;
        else if (to_hit) next_state = F_IDLE;
        else             next_state = F_WAIT;
      end
      F_DONE:  next_state = F_IDLE;
      default: next_state = F_IDLE;
    endcase
  end

  // Fetch FSM per-state actions feeding the registered outputs
  always_comb begin
    ir_load   = 1'b0;
    abort     = 1'b0;
    addr_load = 1'b0;
    busy_req  = 1'b0;
    case (state)
      F_IDLE: begin
        addr_load = en_fetch_pulse;
      end
      F_WAIT: begin
        ir_load  = rom_valid;
        abort    = !rom_valid && to_hit;
        busy_req = en_fetch_pulse;
      end
      F_DONE: begin
        busy_req = en_fetch_pulse;
      end
      default: begin
        ir_load = 1'b0;
      end
    endcase
  end

  // Registered handshakes derived from the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_req <= 1'b0;
      en1     <= 1'b0;
    end else begin
      rom_req <= (next_state == F_WAIT);
      en1     <= (next_state == F_DONE);
    end
  end

  // Capture the fetch address from the pre-update PC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr <= '0;
    end else if (addr_load) begin
      rom_addr <= pc;
    end else begin
      rom_addr <= rom_addr;
    end
  end

  // Instruction register; untouched by aborted fetches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir <= 16'h0000;
    end else if (ir_load) begin
      ir <= rom_data;
    end else begin
      ir <= ir;
    end
  end

  // Timeout counter: counts WAIT cycles without valid, zero elsewhere
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt <= 8'd0;
    end else if ((state == F_WAIT) && !rom_valid && !to_hit) begin
      tcnt <= tcnt + 8'd1;
    end else begin
      tcnt <= 8'd0;
    end
  end

  // Sticky error: timeout or fetch request while busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_err <= 1'b0;
    end else begin
      fetch_err <= fetch_err | abort | busy_req;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: transaction-level model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_fetch_unit;

  localparam int PC_W    = 8;
  localparam int TIMEOUT = 15;

  logic            clk;
  logic            rst;
  logic            en_fetch_pulse;
  logic            en_pc_pulse;
  logic [1:0]      pc_ctrl;
  logic [PC_W-1:0] rom_addr;
  logic            rom_req;
  logic [15:0]     rom_data;
  logic            rom_valid;
  logic            en1;
  logic            pc_jump;
  logic [3:0]      opcode;
  logic [1:0]      rd;
  logic [1:0]      rs;
  logic [7:0]      imm;
  logic [PC_W-1:0] pc;
  logic            fetch_err;

  int checks = 0;
  int errors = 0;

  // ROM contents and responder controls
  logic [15:0] rom [256];
  int          resp_cyc = 1;   // WAIT cycle on which valid comes (0 = never)
  bit          force_valid = 1'b0;
  int          req_cnt = 0;

  // Model state
  int          m_pc = 0;
  logic [15:0] m_ir = 16'h0000;
  bit          m_err = 1'b0;
  int          m_phase = 0;    // 0 idle, 1 waiting on ROM, 2 instruction delivered
  int          m_waited = 0;
  int          m_addr = 0;
  bit          m_jump = 1'b0;

  fetch_unit #(
    .PC_W(PC_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en_fetch_pulse(en_fetch_pulse),
    .en_pc_pulse   (en_pc_pulse),
    .pc_ctrl       (pc_ctrl),
    .rom_addr      (rom_addr),
    .rom_req       (rom_req),
    .rom_data      (rom_data),
    .rom_valid     (rom_valid),
    .en1           (en1),
    .pc_jump       (pc_jump),
    .opcode        (opcode),
    .rd            (rd),
    .rs            (rs),
    .imm           (imm),
    .pc            (pc),
    .fetch_err     (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ROM responder: valid on the chosen WAIT cycle, or forced
  initial begin
    rom_valid = 1'b0;
    rom_data  = 16'h0000;
    forever begin
      @(negedge clk);
      if (rom_req === 1'b1) req_cnt++;
      else                  req_cnt = 0;
      rom_valid = force_valid || ((resp_cyc != 0) && (req_cnt == resp_cyc));
      rom_data  = rom[rom_addr];
    end
  end

  // Behavioural model of the fetch stage
  initial begin
    logic [7:0] imm_old;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_pc = 0; m_ir = 16'h0000; m_err = 1'b0; m_phase = 0;
        m_waited = 0; m_addr = 0; m_jump = 1'b0;
      end else begin
        imm_old = m_ir[7:0];
        m_jump  = 1'b0;
        if (m_phase == 0) begin
          if (en_fetch_pulse) begin
            m_addr = m_pc; m_phase = 1; m_waited = 0;
          end
        end else if (m_phase == 1) begin
          if (en_fetch_pulse) m_err = 1'b1;
          if (rom_valid) begin
            m_ir = rom_data; m_phase = 2;
          end else begin
            m_waited++;
            if (m_waited >= TIMEOUT) begin
              m_err = 1'b1; m_phase = 0;
            end
          end
        end else begin
          if (en_fetch_pulse) m_err = 1'b1;
          m_phase = 0;
        end
        if (en_pc_pulse) begin
          if (pc_ctrl == 2'b01)      m_pc = (m_pc + 1) % 256;
          else if (pc_ctrl == 2'b10) begin m_pc = imm_old; m_jump = 1'b1; end
          else if (pc_ctrl == 2'b11) m_pc = 0;
        end
      end
    end
  end

  // Compare process: every output against the model on every falling edge
  initial begin
    forever begin
      @(negedge clk);
      chk("pc",        pc,        m_pc);
      chk("rom_addr",  rom_addr,  m_addr);
      chk("rom_req",   rom_req,   (m_phase == 1) ? 1 : 0);
      chk("en1",       en1,       (m_phase == 2) ? 1 : 0);
      chk("pc_jump",   pc_jump,   m_jump);
      chk("fetch_err", fetch_err, m_err);
      chk("opcode",    opcode,    m_ir[15:12]);
      chk("rd",        rd,        m_ir[11:10]);
      chk("rs",        rs,        m_ir[9:8]);
      chk("imm",       imm,       m_ir[7:0]);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse(input bit f, input bit p, input logic [1:0] c);
    en_fetch_pulse = f;
    en_pc_pulse    = p;
    pc_ctrl        = c;
    @(negedge clk);
    en_fetch_pulse = 1'b0;
    en_pc_pulse    = 1'b0;
    pc_ctrl        = 2'b00;
  endtask

  initial begin
    int req_cycles;
    int en1_cnt;
    for (int i = 0; i < 256; i++) rom[i] = 16'(i * 3 + 16'h0100);
    rom[0]     = 16'h1A05;
    rom[1]     = 16'h2340;
    rom[8'h40] = 16'h3BFF;
    rom[8'hFF] = 16'hF0AA;

    rst = 1'b1;
    en_fetch_pulse = 1'b0;
    en_pc_pulse    = 1'b0;
    pc_ctrl        = 2'b00;
    tick(); tick();
    rst = 1'b0;
    chk("reset_pc", pc, 0);
    chk("reset_opcode", opcode, 0);
    chk("reset_rom_req", rom_req, 0);
    chk("reset_err", fetch_err, 0);

    // Zero-wait fetch at PC 0 with coincident increment
    resp_cyc = 1;
    pulse(1'b1, 1'b1, 2'b01);
    chk("zw_addr", rom_addr, 0);
    chk("zw_pc", pc, 1);
    chk("zw_req", rom_req, 1);
    chk("zw_en1_early", en1, 0);
    tick();
    chk("zw_en1", en1, 1);
    chk("zw_opcode", opcode, 4'h1);
    chk("zw_rd", rd, 2'd2);
    chk("zw_rs", rs, 2'd2);
    chk("zw_imm", imm, 8'h05);
    tick();
    chk("zw_en1_once", en1, 0);

    // Three-cycle ROM wait at PC 1
    resp_cyc = 3;
    pulse(1'b1, 1'b1, 2'b01);
    req_cycles = 0; en1_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (rom_req) begin
        req_cycles++;
        chk("w3_addr_stable", rom_addr, 1);
      end
      if (en1) en1_cnt++;
      tick();
    end
    chk("w3_req_cycles", req_cycles, 3);
    chk("w3_en1_count", en1_cnt, 1);
    chk("w3_err", fetch_err, 0);
    chk("w3_imm", imm, 8'h40);

    // Jump to imm 0x40, then fetch from there
    pulse(1'b0, 1'b1, 2'b10);
    chk("jmp_pc", pc, 8'h40);
    chk("jmp_pulse", pc_jump, 1);
    tick();
    chk("jmp_pulse_end", pc_jump, 0);
    resp_cyc = 1;
    pulse(1'b1, 1'b0, 2'b00);
    chk("jmp_fetch_addr", rom_addr, 8'h40);
    tick();
    chk("jmp_en1", en1, 1);
    chk("jmp_opcode", opcode, 4'h3);
    chk("jmp_imm", imm, 8'hFF);
    tick();

    // PC wrap: jump to 0xFF, fetch with increment
    pulse(1'b0, 1'b1, 2'b10);
    chk("wrap_pc_ff", pc, 8'hFF);
    pulse(1'b1, 1'b1, 2'b01);
    chk("wrap_addr", rom_addr, 8'hFF);
    chk("wrap_pc", pc, 8'h00);
    tick();
    chk("wrap_opcode", opcode, 4'hF);
    tick();

    // ROM never answers: timeout
    resp_cyc = 0;
    pulse(1'b1, 1'b0, 2'b00);
    req_cycles = 0; en1_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      if (rom_req) req_cycles++;
      if (en1) en1_cnt++;
      tick();
    end
    chk("to_req_cycles", req_cycles, TIMEOUT);
    chk("to_en1", en1_cnt, 0);
    chk("to_err", fetch_err, 1);
    chk("to_ir_kept", imm, 8'hAA);

    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst2_err", fetch_err, 0);
    chk("rst2_pc", pc, 0);

    // Fetch request while busy
    pulse(1'b1, 1'b0, 2'b00);
    chk("busy_err_before", fetch_err, 0);
    pulse(1'b1, 1'b0, 2'b00);
    chk("busy_err", fetch_err, 1);
    chk("busy_req_kept", rom_req, 1);

    // Asynchronous reset mid-WAIT
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req", rom_req, 0);
    chk("arst_err", fetch_err, 0);
    chk("arst_en1", en1, 0);
    chk("arst_opcode", opcode, 0);
    tick(); tick();
    rst = 1'b0;
    force_valid = 1'b1;
    tick();
    chk("late_en1_a", en1, 0);
    tick();
    chk("late_en1_b", en1, 0);
    chk("late_opcode", opcode, 0);
    force_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
